// File: rtl/decode_execute_register_pkg.sv
// Shared processor types used by the ID/EX and later stage registers.
// Holds the ALU opcode type and the control-bit bundle carried through stages.
package decode_execute_register_pkg;

   localparam int ALU_OP_W = 4;
   localparam int BCNT_W   = 16;

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    alu_src;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      alu_op:    '0,
      alu_src:   1'b0,
      mem_read:  1'b0,
      mem_write: 1'b0,
      reg_write: 1'b0
   };

endpackage

// File: rtl/decode_execute_register_hazard_detect.sv
// Load-use hazard comparator between the instruction in EX and the one in ID.
// Purely combinational; register 0 is writable so it gets no exemption.
import decode_execute_register_pkg::*;

module hazard_detect #(
   parameter int D = 5
) (
   input  logic         id_valid,
   input  logic         ex_valid,
   input  logic         ex_mem_read,
   input  logic [D-1:0] ex_rd,
   input  logic [D-1:0] id_rs1,
   input  logic [D-1:0] id_rs2,
   output logic         hazard
);

   logic rs_match;

   // a pending load whose destination feeds either source of decode
   always_comb begin
      rs_match = (ex_rd == id_rs1) | (ex_rd == id_rs2);
      hazard   = id_valid & ex_valid & ex_mem_read & rs_match;
   end

endmodule

// File: rtl/decode_execute_register.sv
// ID/EX pipeline register with load-use bubble insertion and a bubble counter.
// Priority each cycle: reset, stall_in, flush, hazard, then normal capture.
import decode_execute_register_pkg::*;

module decode_execute_register #(
   parameter int D = 5,
   parameter int W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                stall_in,
   input  logic                id_valid,
   input  logic [D-1:0]        id_rs1,
   input  logic [D-1:0]        id_rs2,
   input  logic [D-1:0]        id_rd,
   input  logic [W-1:0]        id_read_data1,
   input  logic [W-1:0]        id_read_data2,
   input  logic [W-1:0]        id_imm,
   input  logic [ALU_OP_W-1:0] id_alu_op,
   input  logic                id_alu_src,
   input  logic                id_mem_read,
   input  logic                id_mem_write,
   input  logic                id_reg_write,
   output logic                ex_valid,
   output logic [D-1:0]        ex_rd,
   output logic [W-1:0]        ex_read_data1,
   output logic [W-1:0]        ex_read_data2,
   output logic [W-1:0]        ex_imm,
   output logic [ALU_OP_W-1:0] ex_alu_op,
   output logic                ex_alu_src,
   output logic                ex_mem_read,
   output logic                ex_mem_write,
   output logic                ex_reg_write,
   output logic                hazard_stall,
   output logic [BCNT_W-1:0]   bubble_count
);

   localparam logic [BCNT_W-1:0] BCNT_MAX = '1;

   logic              valid_q;
   logic [D-1:0]      rd_q;
   logic [W-1:0]      data1_q;
   logic [W-1:0]      data2_q;
   logic [W-1:0]      imm_q;
   ctrl_t             ctrl_q;
   logic [BCNT_W-1:0] bubble_cnt;
   ctrl_t             id_ctrl;
   logic              hazard;

   hazard_detect #(.D(D)) u_hazard (
      .id_valid    (id_valid),
      .ex_valid    (valid_q),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_rd       (rd_q),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .hazard      (hazard)
   );

   // bundle the decoded control bits for a single-field capture
   always_comb begin
      id_ctrl           = CTRL_NOP;
      id_ctrl.alu_op    = id_alu_op;
      id_ctrl.alu_src   = id_alu_src;
      id_ctrl.mem_read  = id_mem_read;
      id_ctrl.mem_write = id_mem_write;
      id_ctrl.reg_write = id_reg_write;
   end

   // stage contents: bubble on reset/flush/hazard, hold on stall, else capture
   always_ff @(posedge clk) begin
      if (reset || (!stall_in && (flush || hazard))) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
         data1_q <= '0;
         data2_q <= '0;
         imm_q   <= '0;
         ctrl_q  <= CTRL_NOP;
      end else if (!stall_in) begin
         valid_q <= id_valid;
         rd_q    <= id_rd;
         data1_q <= id_read_data1;
         data2_q <= id_read_data2;
         imm_q   <= id_imm;
         ctrl_q  <= id_ctrl;
      end
   end

   // count only hazard bubbles; a coincident flush owns the bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_cnt <= '0;
      end else if (!stall_in && !flush && hazard) begin
         if (bubble_cnt != BCNT_MAX) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end
   end

   assign ex_valid      = valid_q;
   assign ex_rd         = rd_q;
   assign ex_read_data1 = data1_q;
   assign ex_read_data2 = data2_q;
   assign ex_imm        = imm_q;
   assign ex_alu_op     = ctrl_q.alu_op;
   assign ex_alu_src    = ctrl_q.alu_src;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign hazard_stall  = hazard;
   assign bubble_count  = bubble_cnt;

endmodule
